// File: rtl/rv32i_types.sv
// Shared types for the BTB prediction / resolution path.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // One instruction's BTB prediction, carried down the pipe beside the instruction
  typedef struct packed {
    logic      valid;
    logic      hit;
    rv32i_word target;
  } btb_pred_t;

  typedef enum logic [2:0] {
    MP_NONE,
    MP_MISS_TAKEN,
    MP_WRONG_TGT,
    MP_NOT_TAKEN,
    MP_ALIAS
  } mispredict_t;

  typedef enum logic {
    BRU_RUN,
    BRU_HOLD
  } bru_state_t;

  // Compare what fetch assumed with what EX resolved
  function automatic mispredict_t classify(input logic is_ctrl, input logic taken,
                                           input logic hit, input rv32i_word pred,
                                           input rv32i_word target);
    if (is_ctrl && taken && !hit)           return MP_MISS_TAKEN;
    if (is_ctrl && taken && pred != target) return MP_WRONG_TGT;
    if (is_ctrl && !taken && hit)           return MP_NOT_TAKEN;
    if (!is_ctrl && hit)                    return MP_ALIAS;
    return MP_NONE;
  endfunction

endpackage

// File: rtl/pred_shadow_reg.sv
// One pipeline stage of shadow prediction state; clear wins over load.
module pred_shadow_reg
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic      clear,
  input  btb_pred_t d,
  output btb_pred_t q
);

  // Capture on advance, drop on flush, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage resolution of BTB predictions: redirect/flush, BTB write-back, perf counters.
module branch_resolve_unit
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             IF_valid,
  input  logic             IF_btb_hit,
  input  logic [31:0]      IF_predicted_pc,
  input  logic             EX_valid,
  input  logic             EX_is_ctrl,
  input  logic             EX_taken,
  input  logic [31:0]      EX_pc,
  input  logic [31:0]      EX_target,
  output logic             btb_load,
  output logic [31:0]      btb_wr_pc,
  output logic [31:0]      btb_wr_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] ctrl_count,
  output logic [CNT_W-1:0] mispredict_count
);

  btb_pred_t   if_pred, id_pred, ex_pred;
  bru_state_t  state, state_nxt;
  mispredict_t mp_kind;

  logic      cand, miss, need_load, latch_hold;
  logic      inc_ctrl, inc_mp;
  rv32i_word fix_pc;

  // Mispredict parked while the pipe is frozen; replayed when the stall drops
  rv32i_word hold_pc, hold_wr_pc, hold_wr_tgt;
  logic      hold_load, hold_ctrl;

  assign if_pred = '{valid: IF_valid, hit: IF_btb_hit, target: IF_predicted_pc};

  pred_shadow_reg u_id_shadow (
    .clk(clk), .rst(rst), .load(!stall), .clear(flush), .d(if_pred), .q(id_pred)
  );

  pred_shadow_reg u_ex_shadow (
    .clk(clk), .rst(rst), .load(!stall), .clear(flush), .d(id_pred), .q(ex_pred)
  );

  // Classification of the instruction currently in EX
  always_comb begin
    cand      = EX_valid && ex_pred.valid && (state == BRU_RUN);
    mp_kind   = classify(EX_is_ctrl, EX_taken, ex_pred.hit, ex_pred.target, EX_target);
    miss      = cand && (mp_kind != MP_NONE);
    need_load = (mp_kind == MP_MISS_TAKEN) || (mp_kind == MP_WRONG_TGT);
    fix_pc    = need_load ? EX_target : EX_pc + 32'd4;
  end

  // Next state and outputs; the HOLD exit cycle carries the deferred BTB write and counts
  always_comb begin
    state_nxt     = state;
    redirect      = 1'b0;
    flush         = 1'b0;
    redirect_pc   = '0;
    btb_load      = 1'b0;
    btb_wr_pc     = '0;
    btb_wr_target = '0;
    inc_ctrl      = 1'b0;
    inc_mp        = 1'b0;
    latch_hold    = 1'b0;
    case (state)
      BRU_RUN: begin
        if (miss) begin
          redirect    = 1'b1;
          flush       = 1'b1;
          redirect_pc = fix_pc;
        end
        if (cand && !stall) begin
          inc_ctrl = EX_is_ctrl;
          inc_mp   = miss;
          if (miss && need_load) begin
            btb_load      = 1'b1;
            btb_wr_pc     = EX_pc;
            btb_wr_target = EX_target;
          end
        end else if (miss && stall) begin
          state_nxt  = BRU_HOLD;
          latch_hold = 1'b1;
        end
      end
      BRU_HOLD: begin
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = hold_pc;
        if (!stall) begin
          state_nxt = BRU_RUN;
          inc_ctrl  = hold_ctrl;
          inc_mp    = 1'b1;
          if (hold_load) begin
            btb_load      = 1'b1;
            btb_wr_pc     = hold_wr_pc;
            btb_wr_target = hold_wr_tgt;
          end
        end
      end
      default: state_nxt = BRU_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BRU_RUN;
    else     state <= state_nxt;
  end

  // Snapshot of the mispredict that hit a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_pc     <= '0;
      hold_wr_pc  <= '0;
      hold_wr_tgt <= '0;
      hold_load   <= 1'b0;
      hold_ctrl   <= 1'b0;
    end else if (latch_hold) begin
      hold_pc     <= fix_pc;
      hold_wr_pc  <= EX_pc;
      hold_wr_tgt <= EX_target;
      hold_load   <= need_load;
      hold_ctrl   <= EX_is_ctrl;
    end
  end

  // Saturating perf counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_count       <= '0;
      mispredict_count <= '0;
    end else begin
      if (inc_ctrl && ctrl_count != {CNT_W{1'b1}})
        ctrl_count <= ctrl_count + 1'b1;
      if (inc_mp && mispredict_count != {CNT_W{1'b1}})
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized run vs. a reference model.
module tb_branch_resolve_unit;

  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall, IF_valid, IF_btb_hit, EX_valid, EX_is_ctrl, EX_taken;
  logic [31:0]   IF_predicted_pc, EX_pc, EX_target;
  logic          btb_load, redirect, flush;
  logic [31:0]   btb_wr_pc, btb_wr_target, redirect_pc;
  logic [CW-1:0] ctrl_count, mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ctrl = 0;
  int exp_mp   = 0;

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .IF_valid(IF_valid), .IF_btb_hit(IF_btb_hit), .IF_predicted_pc(IF_predicted_pc),
    .EX_valid(EX_valid), .EX_is_ctrl(EX_is_ctrl), .EX_taken(EX_taken),
    .EX_pc(EX_pc), .EX_target(EX_target),
    .btb_load(btb_load), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .ctrl_count(ctrl_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    stall = 0; IF_valid = 0; IF_btb_hit = 0; IF_predicted_pc = '0;
    EX_valid = 0; EX_is_ctrl = 0; EX_taken = 0; EX_pc = '0; EX_target = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); clr_in(); rst = 1;
    @(negedge clk); rst = 0;
    exp_ctrl = 0; exp_mp = 0;
  endtask

  task automatic fetch(input logic h, input logic [31:0] p);
    @(negedge clk); clr_in(); IF_valid = 1; IF_btb_hit = h; IF_predicted_pc = p;
  endtask

  task automatic bubble();
    @(negedge clk); clr_in(); #1;
  endtask

  task automatic ex(input logic c, input logic t, input logic [31:0] pc, input logic [31:0] tg,
                    input logic st);
    @(negedge clk); clr_in(); stall = st;
    EX_valid = 1; EX_is_ctrl = c; EX_taken = t; EX_pc = pc; EX_target = tg; #1;
  endtask

  task automatic test_reset();
    clr_in(); rst = 1; #1;
    n_tests++; if ({redirect, flush, btb_load} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags got %b want 000", {redirect, flush, btb_load}); end
    n_tests++; if (redirect_pc !== 32'h0 || btb_wr_pc !== 32'h0) begin n_fail++;
      $display("FAIL reset_pc got %h/%h want 0", redirect_pc, btb_wr_pc); end
    n_tests++; if (ctrl_count !== 0 || mispredict_count !== 0) begin n_fail++;
      $display("FAIL reset_cnt got %0d/%0d want 0", ctrl_count, mispredict_count); end
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic test_miss_taken();
    fetch(0, 32'h0); bubble(); ex(1, 1, 32'h60, 32'h100, 0);
    n_tests++; if ({redirect, flush, btb_load} !== 3'b111 || redirect_pc !== 32'h100) begin n_fail++;
      $display("FAIL miss_taken got r%b f%b l%b pc %h want 111 pc 100", redirect, flush, btb_load, redirect_pc); end
    n_tests++; if (btb_wr_pc !== 32'h60 || btb_wr_target !== 32'h100) begin n_fail++;
      $display("FAIL miss_taken_wr got %h/%h want 60/100", btb_wr_pc, btb_wr_target); end
    exp_ctrl++; exp_mp++;
    bubble();
    n_tests++; if (ctrl_count !== exp_ctrl[CW-1:0] || mispredict_count !== exp_mp[CW-1:0]) begin n_fail++;
      $display("FAIL miss_taken_cnt got %0d/%0d want %0d/%0d", ctrl_count, mispredict_count, exp_ctrl, exp_mp); end
  endtask

  task automatic test_correct();
    fetch(1, 32'h100); bubble(); ex(1, 1, 32'h60, 32'h100, 0);
    n_tests++; if ({redirect, flush, btb_load} !== 3'b000) begin n_fail++;
      $display("FAIL correct got r%b f%b l%b want 000", redirect, flush, btb_load); end
    exp_ctrl++;
    bubble();
    n_tests++; if (ctrl_count !== exp_ctrl[CW-1:0] || mispredict_count !== exp_mp[CW-1:0]) begin n_fail++;
      $display("FAIL correct_cnt got %0d/%0d want %0d/%0d", ctrl_count, mispredict_count, exp_ctrl, exp_mp); end
  endtask

  task automatic test_not_taken();
    fetch(1, 32'h100); bubble(); ex(1, 0, 32'h60, 32'h100, 0);
    n_tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h64 || btb_load !== 1'b0) begin n_fail++;
      $display("FAIL not_taken got r%b pc %h l%b want 1 64 0", redirect, redirect_pc, btb_load); end
    exp_ctrl++; exp_mp++;
    bubble();
  endtask

  task automatic test_wrap_alias();
    fetch(1, 32'h200); bubble(); ex(0, 0, 32'hFFFF_FFFC, 32'h0, 0);
    n_tests++; if (redirect !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h0 || btb_load !== 1'b0) begin n_fail++;
      $display("FAIL wrap_alias got r%b f%b pc %h l%b want 1 1 0 0", redirect, flush, redirect_pc, btb_load); end
    exp_mp++;
    bubble();
    n_tests++; if (ctrl_count !== exp_ctrl[CW-1:0] || mispredict_count !== exp_mp[CW-1:0]) begin n_fail++;
      $display("FAIL alias_cnt got %0d/%0d want %0d/%0d", ctrl_count, mispredict_count, exp_ctrl, exp_mp); end
  endtask

  task automatic test_stall_hold();
    int loads = 0;
    fetch(0, 32'h0); bubble();
    for (int i = 0; i < 3; i++) begin
      ex(1, 1, 32'h60, 32'h100, 1);
      n_tests++; if (redirect !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h100 || btb_load !== 1'b0) begin n_fail++;
        $display("FAIL hold_%0d got r%b f%b pc %h l%b want 1 1 100 0", i, redirect, flush, redirect_pc, btb_load); end
      n_tests++; if (mispredict_count !== exp_mp[CW-1:0]) begin n_fail++;
        $display("FAIL hold_cnt_%0d got %0d want %0d", i, mispredict_count, exp_mp); end
    end
    ex(1, 1, 32'h60, 32'h100, 0);
    if (btb_load) loads++;
    n_tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h100 || btb_wr_pc !== 32'h60 || btb_wr_target !== 32'h100) begin n_fail++;
      $display("FAIL hold_exit got r%b pc %h wr %h/%h want 1 100 60/100", redirect, redirect_pc, btb_wr_pc, btb_wr_target); end
    exp_ctrl++; exp_mp++;
    // Shadow regs were flushed, so a new EX instruction finds no prediction to resolve
    ex(1, 1, 32'h80, 32'h300, 0);
    if (btb_load) loads++;
    n_tests++; if (redirect !== 1'b0 || loads != 1) begin n_fail++;
      $display("FAIL hold_after got r%b loads %0d want 0 1", redirect, loads); end
    bubble();
    n_tests++; if (ctrl_count !== exp_ctrl[CW-1:0] || mispredict_count !== exp_mp[CW-1:0]) begin n_fail++;
      $display("FAIL hold_final_cnt got %0d/%0d want %0d/%0d", ctrl_count, mispredict_count, exp_ctrl, exp_mp); end
  endtask

  task automatic test_rst_in_hold();
    fetch(0, 32'h0); bubble(); ex(1, 1, 32'h60, 32'h100, 1);
    @(negedge clk); #1;
    n_tests++; if (redirect !== 1'b1) begin n_fail++;
      $display("FAIL pre_rst_hold got %b want 1", redirect); end
    #2 rst = 1; #1;
    n_tests++; if ({redirect, flush, btb_load} !== 3'b000 || redirect_pc !== 32'h0) begin n_fail++;
      $display("FAIL rst_in_hold got r%b f%b l%b pc %h want 0", redirect, flush, btb_load, redirect_pc); end
    n_tests++; if (ctrl_count !== 0 || mispredict_count !== 0) begin n_fail++;
      $display("FAIL rst_in_hold_cnt got %0d/%0d want 0", ctrl_count, mispredict_count); end
    @(negedge clk); clr_in(); rst = 0; exp_ctrl = 0; exp_mp = 0;
    ex(1, 1, 32'h60, 32'h100, 0);
    n_tests++; if (redirect !== 1'b0) begin n_fail++;
      $display("FAIL post_rst_run got %b want 0", redirect); end
  endtask

  task automatic test_saturate();
    do_reset();
    // Steady stream of correctly predicted not-taken branches, one per cycle
    for (int i = 0; i < MAXC + 20; i++) begin
      @(negedge clk); clr_in();
      IF_valid = 1; EX_valid = 1; EX_is_ctrl = 1; EX_pc = 32'h40;
    end
    bubble();
    n_tests++; if (ctrl_count !== MAXC[CW-1:0] || mispredict_count !== 0) begin n_fail++;
      $display("FAIL sat_ctrl got %0d/%0d want %0d/0", ctrl_count, mispredict_count, MAXC); end
    for (int i = 0; i < 3 * MAXC + 30; i++) begin
      @(negedge clk); clr_in();
      IF_valid = 1; EX_valid = 1; EX_is_ctrl = 1; EX_taken = 1; EX_pc = 32'h40; EX_target = 32'h80;
    end
    bubble();
    n_tests++; if (ctrl_count !== MAXC[CW-1:0] || mispredict_count !== MAXC[CW-1:0]) begin n_fail++;
      $display("FAIL sat_mp got %0d/%0d want %0d/%0d", ctrl_count, mispredict_count, MAXC, MAXC); end
  endtask

  typedef struct packed { logic v; logic h; logic [31:0] t; } md_t;

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(0, 2))
      0:       return 32'h100;
      1:       return 32'h200;
      default: return 32'h300;
    endcase
  endfunction

  task automatic test_random();
    md_t mid, mex;
    bit mhold, hld, hctl, ok, ld, wrong, e_red, e_ld;
    logic [31:0] hpc, hwp, hwt, fix, e_pc, e_wp, e_wt;
    int ec, em, bad;
    do_reset();
    mid = '0; mex = '0; mhold = 0; hld = 0; hctl = 0; hpc = '0; hwp = '0; hwt = '0;
    ec = 0; em = 0; bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      IF_valid = ($urandom_range(0, 3) != 0);
      IF_btb_hit = $urandom_range(0, 1);
      IF_predicted_pc = pick_tgt();
      EX_valid = ($urandom_range(0, 4) != 0);
      EX_is_ctrl = ($urandom_range(0, 3) != 0);
      EX_taken = $urandom_range(0, 1);
      EX_pc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 255) << 2);
      EX_target = pick_tgt();
      #1;
      ok    = !mhold && EX_valid && mex.v;
      ld    = EX_is_ctrl && EX_taken && (!mex.h || mex.t != EX_target);
      wrong = ld || (!(EX_is_ctrl && EX_taken) && mex.h);
      fix   = ld ? EX_target : EX_pc + 32'd4;
      e_red = mhold || (ok && wrong);
      e_pc  = mhold ? hpc : (e_red ? fix : 32'h0);
      e_ld  = !stall && (mhold ? hld : (ok && ld));
      e_wp  = !e_ld ? 32'h0 : (mhold ? hwp : EX_pc);
      e_wt  = !e_ld ? 32'h0 : (mhold ? hwt : EX_target);
      n_tests++;
      if ({redirect, flush, btb_load} !== {e_red, e_red, e_ld} || redirect_pc !== e_pc ||
          btb_wr_pc !== e_wp || btb_wr_target !== e_wt ||
          ctrl_count !== ec[CW-1:0] || mispredict_count !== em[CW-1:0]) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL rand cyc %0d got r%b f%b l%b pc %h wr %h/%h cnt %0d/%0d want r%b l%b pc %h wr %h/%h cnt %0d/%0d",
                   i, redirect, flush, btb_load, redirect_pc, btb_wr_pc, btb_wr_target, ctrl_count,
                   mispredict_count, e_red, e_ld, e_pc, e_wp, e_wt, ec, em);
        bad++;
      end
      // Advance the model across the coming edge
      if (mhold) begin
        if (!stall) begin
          mhold = 0;
          if (hctl && ec < MAXC) ec++;
          if (em < MAXC) em++;
        end
      end else if (ok && !stall) begin
        if (EX_is_ctrl && ec < MAXC) ec++;
        if (wrong && em < MAXC) em++;
      end else if (ok && wrong && stall) begin
        mhold = 1; hpc = fix; hld = ld; hwp = EX_pc; hwt = EX_target; hctl = EX_is_ctrl;
      end
      if (e_red) begin
        mid.v = 0; mex.v = 0;
      end else if (!stall) begin
        mex = mid;
        mid = '{v: IF_valid, h: IF_btb_hit, t: IF_predicted_pc};
      end
    end
    bubble();
  endtask

  initial begin
    test_reset();
    test_miss_taken();
    test_correct();
    test_not_taken();
    test_wrap_alias();
    test_stall_hold();
    test_rst_in_hold();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
